// File: rtl/fdma_bram_responder_if.sv
// +----------------------------------------------------------------------------+
// | fdma_bram_responder_if                                                     |
// | FDMA write/read channel bundle between an initiator and a responder.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fdma_bram_responder_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 29
);
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wareq;
  logic [15:0]           wsize;
  logic                  wbusy;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  rareq;
  logic [15:0]           rsize;
  logic                  rbusy;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output waddr, wareq, wsize, wdata, wready,
    output raddr, rareq, rsize, rready,
    input  wbusy, wvalid, rbusy, rdata, rvalid
  );

  modport slave (
    input  waddr, wareq, wsize, wdata, wready,
    input  raddr, rareq, rsize, rready,
    output wbusy, wvalid, rbusy, rdata, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/fdma_bram_responder.sv
// +----------------------------------------------------------------------------+
// | fdma_bram_responder                                                        |
// | Terminates FDMA write/read bursts in a single-port on-chip RAM.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fdma_bram_responder #(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 29,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  wire logic            I_clk,
  input  wire logic            I_rstn,
  fdma_bram_responder_if.slave fdma_io
);
  localparam int OFF   = $clog2(DATA_WIDTH / 8);
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  logic [1:0]                state_q, state_d;
  logic                      last_rd_q, last_rd_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [15:0]               size_q, size_d;
  logic [15:0]               beat_q, beat_d;
  logic [15:0]               rx_q, rx_d;
  logic                      out_v_q, out_v_d;
  logic                      skid_v_q, skid_v_d;
  logic [DATA_WIDTH-1:0]     out_q;
  logic [DATA_WIDTH-1:0]     skid_q;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic                      w_wreq, w_rreq, w_grant_w, w_grant_r;
  logic                      w_we, w_re, w_pop;
  logic                      w_load_out, w_load_skid, w_out_from_skid;
  logic [MEM_ADDR_WIDTH-1:0] w_idx, w_wbase, w_rbase;

  assign w_wbase = MEM_ADDR_WIDTH'(ADDR_WIDTH'(fdma_io.waddr) >> OFF);
  assign w_rbase = MEM_ADDR_WIDTH'(ADDR_WIDTH'(fdma_io.raddr) >> OFF);
  assign w_idx   = base_q + MEM_ADDR_WIDTH'(beat_q);

  // Zero-length requests are never granted; ties go to the channel not served last.
  assign w_wreq    = fdma_io.wareq && (fdma_io.wsize != 16'd0);
  assign w_rreq    = fdma_io.rareq && (fdma_io.rsize != 16'd0);
  assign w_grant_w = w_wreq && (!w_rreq || last_rd_q);
  assign w_grant_r = w_rreq && !w_grant_w;

  assign w_we  = (state_q == S_WRITE) && fdma_io.wready;
  assign w_pop = out_v_q && fdma_io.rready;
  // Issue a RAM read only if the output/skid pair cannot end up over-full.
  assign w_re  = (state_q == S_READ) && (beat_q != size_q) &&
                 !(out_v_q && skid_v_q && !w_pop);

  assign fdma_io.wbusy  = (state_q == S_WRITE);
  assign fdma_io.wvalid = (state_q == S_WRITE);
  assign fdma_io.rbusy  = (state_q == S_READ);
  assign fdma_io.rvalid = out_v_q;
  assign fdma_io.rdata  = out_q;

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    base_d    = base_q;
    size_d    = size_q;
    beat_d    = beat_q;
    rx_d      = rx_q;
    case (state_q)
      S_IDLE: begin
        if (w_grant_w) begin
          state_d   = S_WRITE;
          last_rd_d = 1'b0;
          base_d    = w_wbase;
          size_d    = fdma_io.wsize;
          beat_d    = 16'd0;
          rx_d      = 16'd0;
        end else if (w_grant_r) begin
          state_d   = S_READ;
          last_rd_d = 1'b1;
          base_d    = w_rbase;
          size_d    = fdma_io.rsize;
          beat_d    = 16'd0;
          rx_d      = 16'd0;
        end
      end
      S_WRITE: begin
        if (w_we) begin
          beat_d = beat_q + 16'd1;
          if (beat_q == size_q - 16'd1) state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (w_re) beat_d = beat_q + 16'd1;
        if (w_pop) begin
          rx_d = rx_q + 16'd1;
          if (rx_q == size_q - 16'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Skid is only ever occupied behind a valid output register.
  always_comb begin
    out_v_d         = out_v_q;
    skid_v_d        = skid_v_q;
    w_load_out      = 1'b0;
    w_load_skid     = 1'b0;
    w_out_from_skid = 1'b0;
    if (w_pop) begin
      if (skid_v_q) begin
        w_out_from_skid = 1'b1;
        skid_v_d        = w_re;
        w_load_skid     = w_re;
      end else begin
        out_v_d    = w_re;
        w_load_out = w_re;
      end
    end else if (w_re) begin
      if (out_v_q) begin
        skid_v_d    = 1'b1;
        w_load_skid = 1'b1;
      end else begin
        out_v_d    = 1'b1;
        w_load_out = 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state_q   <= S_IDLE;
      last_rd_q <= 1'b1;
      base_q    <= '0;
      size_q    <= 16'd0;
      beat_q    <= 16'd0;
      rx_q      <= 16'd0;
      out_v_q   <= 1'b0;
      skid_v_q  <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      base_q    <= base_d;
      size_q    <= size_d;
      beat_q    <= beat_d;
      rx_q      <= rx_d;
      out_v_q   <= out_v_d;
      skid_v_q  <= skid_v_d;
      if (w_out_from_skid) out_q <= skid_q;
      else if (w_load_out) out_q <= mem[w_idx];
      if (w_load_skid) skid_q <= mem[w_idx];
    end
  end

  always_ff @(posedge I_clk) begin
    if (w_we) mem[w_idx] <= fdma_io.wdata;
  end
endmodule

`default_nettype wire
